fdivsqrt_issueq: RTL and testbench
==================================

# fdivsqrt_issueq

Request-side issue controller for the iterative divide/square-root unit. It buffers divide and sqrt requests from the execute stage in a small FIFO, issues them one at a time as single-cycle start pulses while the unit is not busy, and captures each done-cycle result. Results are returned in order on a valid/ready response port toward writeback, and a flush discards all pending and in-flight work.

## Interface
Parameters:
- OPW, 128: width of the opaque operand/control bundle forwarded to the divider.
- RESW, 64: result width.
- TAGW, 5: destination tag width.
- DEPTH, 4: request FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, sole clock domain.
- ReqValid  in  1  request present.
- ReqReady  out  1  FIFO not full.
- ReqOp  in  OPW  operand bundle.
- ReqTag  in  TAGW  destination tag.
- Flush  in  1  kill all queued, in-flight and held work.
- DivStart  out  1  one-cycle issue pulse.
- DivOp  out  OPW  bundle at FIFO head, valid while DivStart=1.
- DivBusy  in  1  divider iterating.
- DivDone  in  1  one-cycle completion pulse.
- DivResult  in  RESW  valid only while DivDone=1.
- RspValid  out  1  held result available.
- RspReady  in  1  consumer accepts.
- RspResult  out  RESW  held result.
- RspTag  out  TAGW  tag of held result.
- PendCnt  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FSM states: IDLE, WAIT, HOLD, DRAIN. A separate tag register holds the in-flight tag.
- IDLE: DivStart = FIFO non-empty & !DivBusy & !Flush. On DivStart, pop the head, latch its tag, and go to WAIT.
- WAIT: on DivDone, capture DivResult and the in-flight tag into the hold register, then go to HOLD.
- HOLD: RspValid=1. On RspValid&RspReady go to IDLE. No new issue happens during HOLD, so results stay in order.
- DRAIN: waits for DivDone and discards it, then goes to IDLE. DivStart=0 throughout.
- Flush, which has priority over every other event in its cycle:
  - Empties the FIFO. A ReqValid in the same cycle is not enqueued.
  - From WAIT, the FSM goes to DRAIN. If DivDone arrives in the same cycle, the result is discarded and the FSM goes to IDLE.
  - From HOLD, the result is dropped and the FSM goes to IDLE.
  - From DRAIN or IDLE, the FSM goes to or stays in IDLE.
- DivDone in IDLE or HOLD is ignored (protocol error, no state change).
- ReqReady = !full. It does not depend on a same-cycle pop, so there is no combinational path from DivBusy.
- Push and pop in the same cycle leave PendCnt unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty is determined by PendCnt.
- Reset:
  - State is IDLE; FIFO empty; PendCnt=0.
  - DivStart=0, RspValid=0, RspResult=0, RspTag=0.
  - ReqReady=1 from the first post-reset cycle.
  - Reset during WAIT does not wait for the divider; the divider must be reset by the same reset.

## Timing
- Without bypass: request accepted at edge N is issued with DivStart in cycle N+1 if the FSM is IDLE and DivBusy=0.
- Divider latency L cycles from DivStart to DivDone gives RspValid in the cycle after DivDone. RspValid stays high until handshake.
- Back-to-back: a response handshake at edge M makes the next DivStart possible in cycle M+1.
- DivOp, RspResult and RspTag are register outputs with no combinational path from inputs. The exception is bypass mode, below.

## Configuration
- FDIVSQRT_ISSUEQ_BYPASS_EN defined:
  - In IDLE with the FIFO empty and DivBusy=0, ReqValid&ReqReady drives DivStart in the same cycle.
  - DivOp is ReqOp (combinational mux) and the request is not written to the FIFO.
  - Zero-cycle issue latency.
- Undefined: every request passes through the FIFO; minimum one-cycle issue latency. All other behaviour is identical.

## Structure
- The state enum (IDLE/WAIT/HOLD/DRAIN) goes in the shared config_pkg as a typedef, alongside the default widths.
- One sub-module, issueq_fifo: synchronous FIFO with push, pop, flush, full, empty and count.
- The FSM, tag register and hold register stay in the top module.

## Test plan
- Reset, then a single request (tag 3, divider L=10) → DivStart in cycle 1 after acceptance (cycle 0 with bypass), DivDone at +10, RspValid=1 with tag 3 the next cycle. RspReady=1 → IDLE.
- Push 5 requests with DEPTH=4 and DivBusy held at 1 → ReqReady=0 after the 4th; the 5th is held until a pop; PendCnt reaches 4 and never exceeds it.
- Hold RspReady=0 for 20 cycles with 2 queued → RspValid, RspTag and RspResult stay stable, and no DivStart occurs until the handshake.
- Flush in WAIT with 2 queued → PendCnt=0 next cycle, DRAIN; DivDone is discarded, no RspValid, and the next request issues normally.
- Flush in the same cycle as DivDone and ReqValid → no response, nothing enqueued, IDLE next cycle.
- Randomized tags across 100 ops with random RspReady → responses arrive in order and tags match the request order exactly.

Source files
------------

// File: rtl/fdivsqrt_issueq_pkg.sv
// Shared types and default widths for the divide/sqrt issue controller.
package fdivsqrt_issueq_pkg;

  localparam int DEF_OPW   = 128;
  localparam int DEF_RESW  = 64;
  localparam int DEF_TAGW  = 5;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/fdivsqrt_issueq_fifo.sv
// Request FIFO for the divide/sqrt issue controller: push/pop/flush with
// occupancy count; full and empty are derived from the count.
module issueq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset; entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/fdivsqrt_issueq.sv
// Issue controller for the iterative divide/sqrt unit: queues requests, issues
// them one at a time, holds each result for in-order writeback. Optional
// same-cycle issue from an empty queue with FDIVSQRT_ISSUEQ_BYPASS_EN.
//
// state | meaning
// IDLE  | free to issue the next request
// WAIT  | request in flight, waiting for DivDone
// HOLD  | result held on the response port until accepted
// DRAIN | flushed request still in flight, its DivDone is discarded
module fdivsqrt_issueq
  import fdivsqrt_issueq_pkg::*;
#(
  parameter int OPW   = DEF_OPW,
  parameter int RESW  = DEF_RESW,
  parameter int TAGW  = DEF_TAGW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic [OPW-1:0]         ReqOp,
  input  logic [TAGW-1:0]        ReqTag,
  input  logic                   Flush,
  output logic                   DivStart,
  output logic [OPW-1:0]         DivOp,
  input  logic                   DivBusy,
  input  logic                   DivDone,
  input  logic [RESW-1:0]        DivResult,
  output logic                   RspValid,
  input  logic                   RspReady,
  output logic [RESW-1:0]        RspResult,
  output logic [TAGW-1:0]        RspTag,
  output logic [$clog2(DEPTH):0] PendCnt
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TAGW-1:0]       r_tag;
  logic [RESW-1:0]       r_rsp_result;
  logic [TAGW-1:0]       r_rsp_tag;

  logic [OPW+TAGW-1:0]   w_head;
  logic [OPW-1:0]        w_head_op;
  logic [TAGW-1:0]       w_head_tag;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_can_issue;
  logic                  w_issue_q;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_capture;
  logic [TAGW-1:0]       w_start_tag;

  assign w_head_op  = w_head[OPW+TAGW-1:TAGW];
  assign w_head_tag = w_head[TAGW-1:0];

  assign w_can_issue = (r_state == IDLE) & ~DivBusy & ~Flush;
  assign w_issue_q   = w_can_issue & ~w_empty;

`ifdef FDIVSQRT_ISSUEQ_BYPASS_EN
  assign w_bypass = w_can_issue & w_empty & ReqValid & ~w_full;
  assign DivOp    = w_bypass ? ReqOp : w_head_op;
`else
  assign w_bypass = 1'b0;
  assign DivOp    = w_head_op;
`endif

  assign w_push      = ReqValid & ~w_full & ~Flush & ~w_bypass;
  assign DivStart    = w_issue_q | w_bypass;
  assign w_start_tag = w_bypass ? ReqTag : w_head_tag;

  // Ready looks only at occupancy, never at this cycle's pop.
  assign ReqReady  = ~w_full;
  assign RspValid  = (r_state == HOLD);
  assign RspResult = r_rsp_result;
  assign RspTag    = r_rsp_tag;

  issueq_fifo #(
    .W     (OPW + TAGW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_issue_q),
    .i_flush (Flush),
    .i_wdata ({ReqOp, ReqTag}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (PendCnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (DivStart) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (Flush) begin
          w_state_nxt = DivDone ? IDLE : DRAIN;
        end else if (DivDone) begin
          w_state_nxt = HOLD;
          w_capture   = 1'b1;
        end
      end
      HOLD: begin
        if (Flush || RspReady) w_state_nxt = IDLE;
      end
      DRAIN: begin
        if (Flush || DivDone) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_tag        <= '0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (DivStart) r_tag <= w_start_tag;
      if (w_capture) begin
        r_rsp_result <= DivResult;
        r_rsp_tag    <= r_tag;
      end
    end
  end

endmodule

// File: tb/tb_fdivsqrt_issueq.sv
// Scoreboard bench for fdivsqrt_issueq with a behavioural fixed-latency divider.
module tb_fdivsqrt_issueq;

  localparam int OPW   = 128;
  localparam int RESW  = 64;
  localparam int TAGW  = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FDIVSQRT_ISSUEQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            ReqValid;
  logic            ReqReady;
  logic [OPW-1:0]  ReqOp;
  logic [TAGW-1:0] ReqTag;
  logic            Flush;
  logic            DivStart;
  logic [OPW-1:0]  DivOp;
  logic            DivBusy;
  logic            DivDone;
  logic [RESW-1:0] DivResult;
  logic            RspValid;
  logic            RspReady;
  logic [RESW-1:0] RspResult;
  logic [TAGW-1:0] RspTag;
  logic [CW-1:0]   PendCnt;

  always #5 clk = ~clk;

  fdivsqrt_issueq #(.OPW(OPW), .RESW(RESW), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqTag(ReqTag), .Flush(Flush), .DivStart(DivStart),
    .DivOp(DivOp), .DivBusy(DivBusy), .DivDone(DivDone), .DivResult(DivResult),
    .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult),
    .RspTag(RspTag), .PendCnt(PendCnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;
  logic pend_over = 1'b0;
  logic [TAGW-1:0] exp_tag_q[$];
  logic [RESW-1:0] exp_res_q[$];

  logic          dv_busy;
  logic          force_busy;
  int            busy_cnt;
  int            lat;
  logic [OPW-1:0] dv_op;
  logic          sending_done;

  assign DivBusy = dv_busy | force_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Divider model: DivDone arrives lat cycles after the DivStart cycle.
  initial begin
    logic st;
    logic [OPW-1:0] op;
    dv_busy = 1'b0; DivDone = 1'b0; DivResult = '0; busy_cnt = 0; dv_op = '0;
    forever begin
      @(negedge clk);
      st = DivStart;
      op = DivOp;
      @(posedge clk);
      #1;
      DivDone = 1'b0;
      if (reset) begin
        dv_busy = 1'b0;
      end else if (st) begin
        dv_busy  = 1'b1;
        busy_cnt = lat - 1;
        dv_op    = op;
      end else if (dv_busy) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          dv_busy   = 1'b0;
          DivDone   = 1'b1;
          DivResult = dv_op[63:0] + 64'h1234;
        end
      end
    end
  end

  // Monitor: accepted requests feed the scoreboard, handshakes drain it.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (PendCnt > CW'(DEPTH)) pend_over = 1'b1;
        if (Flush) begin
          exp_tag_q.delete();
          exp_res_q.delete();
        end else begin
          if (ReqValid && ReqReady) begin
            exp_tag_q.push_back(ReqTag);
            exp_res_q.push_back(ReqOp[63:0] + 64'h1234);
          end
          if (RspValid && RspReady) begin
            check("rsp_expected", 64'(exp_tag_q.size() != 0), 64'(1));
            if (exp_tag_q.size() != 0) begin
              check("rsp_tag", 64'(RspTag), 64'(exp_tag_q.pop_front()));
              check("rsp_result", RspResult, exp_res_q.pop_front());
              n_rsp++;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [TAGW-1:0] t, input logic [OPW-1:0] op);
    int n;
    tick();
    ReqValid = 1'b1;
    ReqTag   = t;
    ReqOp    = op;
    @(negedge clk);
    n = 0;
    while (!ReqReady && n < 100) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 64'(n), 64'(0));
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (exp_tag_q.size() != 0 && n < max) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < max), 64'(1));
    tick();
    @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, i, rc, sc, nb;
    logic stable;
    logic [TAGW-1:0] ht;
    logic [RESW-1:0] hr;

    reset = 1'b1; ReqValid = 1'b0; ReqOp = '0; ReqTag = '0; Flush = 1'b0;
    RspReady = 1'b1; force_busy = 1'b0; lat = 10; sending_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_reqready", 64'(ReqReady), 64'(1));
    check("rst_rspvalid", 64'(RspValid), 64'(0));
    check("rst_divstart", 64'(DivStart), 64'(0));
    check("rst_pendcnt", 64'(PendCnt), 64'(0));
    check("rst_rspresult", RspResult, 64'(0));
    check("rst_rsptag", 64'(RspTag), 64'(0));

    // Single request, tag 3, L=10
    tick();
    ReqValid = 1'b1; ReqTag = 5'd3; ReqOp = 128'd100;
    @(negedge clk);
    check("t1_start_accept_cycle", 64'(DivStart), 64'(BYP));
    tick();
    ReqValid = 1'b0;
    @(negedge clk);
    check("t1_start_next_cycle", 64'(DivStart), 64'(!BYP));
    check("t1_pendcnt", 64'(PendCnt), BYP ? 64'(0) : 64'(1));
    n = BYP ? 1 : 0;
    while (!RspValid && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("t1_rsp_latency", 64'(n), 64'(11));
    check("t1_rsp_tag_direct", 64'(RspTag), 64'(3));
    tick();
    @(negedge clk);
    check("t1_idle_after_hs", 64'(RspValid), 64'(0));

    // Fill the FIFO while the divider reports busy
    force_busy = 1'b1;
    i = 0; n = 0;
    while (i < 4 && n < 50) begin
      tick();
      ReqValid = 1'b1; ReqTag = 5'(10 + i); ReqOp = 128'(1000 + i);
      @(negedge clk);
      if (ReqReady) i++;
      n++;
    end
    tick();
    ReqValid = 1'b1; ReqTag = 5'd14; ReqOp = 128'd1004;
    @(negedge clk);
    check("t2_full_reqready", 64'(ReqReady), 64'(0));
    check("t2_full_pendcnt", 64'(PendCnt), 64'(4));
    repeat (3) begin
      tick();
      @(negedge clk);
    end
    check("t2_fifth_held", 64'(PendCnt), 64'(4));
    tick();
    force_busy = 1'b0;
    @(negedge clk);
    check("t2_issue_after_unbusy", 64'(DivStart), 64'(1));
    check("t2_ready_no_comb_pop", 64'(ReqReady), 64'(0));
    tick();
    @(negedge clk);
    check("t2_pendcnt_after_pop", 64'(PendCnt), 64'(3));
    tick();
    ReqValid = 1'b0;
    @(negedge clk);
    check("t2_pendcnt_after_fifth", 64'(PendCnt), 64'(4));
    wait_drain(300);

    // Backpressure on the response port with two queued
    RspReady = 1'b0;
    send(5'd20, 128'd2000);
    send(5'd21, 128'd2001);
    send(5'd22, 128'd2002);
    tick();
    ReqValid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!RspValid && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("t3_rsp_seen", 64'(RspValid), 64'(1));
    check("t3_pendcnt", 64'(PendCnt), 64'(2));
    check("t3_first_tag", 64'(RspTag), 64'(20));
    ht = RspTag; hr = RspResult; stable = 1'b1; sc = 0;
    repeat (20) begin
      tick();
      @(negedge clk);
      if (!RspValid || RspTag !== ht || RspResult !== hr) stable = 1'b0;
      if (DivStart) sc++;
    end
    check("t3_hold_stable", 64'(stable), 64'(1));
    check("t3_no_start_in_hold", 64'(sc), 64'(0));
    tick();
    RspReady = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("t3_start_after_hs", 64'(DivStart), 64'(1));
    wait_drain(200);

    // Flush while WAIT with two queued
    send(5'd1, 128'd500);
    send(5'd2, 128'd501);
    send(5'd4, 128'd502);
    tick();
    ReqValid = 1'b0;
    @(negedge clk);
    check("t4_pendcnt_before", 64'(PendCnt), 64'(2));
    tick();
    Flush = 1'b1;
    @(negedge clk);
    tick();
    Flush = 1'b0;
    @(negedge clk);
    check("t4_pendcnt_flushed", 64'(PendCnt), 64'(0));
    check("t4_rspvalid_flushed", 64'(RspValid), 64'(0));
    nb = n_rsp; rc = 0; sc = 0;
    repeat (15) begin
      tick();
      @(negedge clk);
      if (RspValid) rc++;
      if (DivStart) sc++;
    end
    check("t4_no_rsp", 64'(rc), 64'(0));
    check("t4_no_start_drain", 64'(sc), 64'(0));
    send(5'd7, 128'd700);
    tick();
    ReqValid = 1'b0;
    @(negedge clk);
    wait_drain(100);
    check("t4_post_flush_rsp", 64'(n_rsp - nb), 64'(1));

    // Flush coinciding with DivDone and ReqValid
    send(5'd9, 128'd900);
    tick();
    ReqValid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(dv_busy && busy_cnt == 1) && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    tick();
    Flush = 1'b1; ReqValid = 1'b1; ReqTag = 5'd30; ReqOp = 128'd3000;
    @(negedge clk);
    check("t5_done_coincide", 64'(DivDone), 64'(1));
    tick();
    Flush = 1'b0; ReqValid = 1'b0;
    @(negedge clk);
    check("t5_rspvalid", 64'(RspValid), 64'(0));
    check("t5_pendcnt", 64'(PendCnt), 64'(0));
    rc = 0; sc = 0;
    repeat (5) begin
      tick();
      @(negedge clk);
      if (RspValid) rc++;
      if (DivStart) sc++;
    end
    check("t5_no_rsp", 64'(rc), 64'(0));
    check("t5_no_start", 64'(sc), 64'(0));

    // 100 ops, random tags, varying latency, random RspReady
    nb = n_rsp;
    fork
      begin
        for (int k = 0; k < 100; k++) begin
          lat = int'($urandom_range(2, 6));
          send(5'($urandom_range(0, 31)), 128'(k * 7 + 5));
        end
        tick();
        ReqValid = 1'b0;
        sending_done = 1'b1;
      end
      begin
        while (!sending_done) begin
          tick();
          RspReady = 1'($urandom_range(0, 1));
        end
      end
    join
    RspReady = 1'b1;
    wait_drain(500);
    check("t6_rsp_count", 64'(n_rsp - nb), 64'(100));
    check("pend_never_over", 64'(pend_over), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
